// File: rtl/ondra_pkg.sv
// ondra_pkg: shared types and constants for the Ondra boot-time video configuration loader.
package ondra_pkg;
  typedef enum logic [1:0] {HOLD, SAMPLE, RELEASE, RUN} state_e;
  localparam logic [18:0] CFG_ADDR_DEFAULT = 19'h08FD5;
  localparam logic [7:0] PS2_SCROLLLOCK = 8'h7E;
  localparam int STB = 10;
  localparam int PRESSED = 9;
  localparam int EXT = 8;
endpackage

// File: rtl/ps2_hotkey_det.sv
// ps2_hotkey_det: one-cycle pulse when a fresh non-extended press of HOTKEY arrives on the ps2_key bus.
module ps2_hotkey_det
  import ondra_pkg::*;
#(
  parameter logic [7:0] HOTKEY = PS2_SCROLLLOCK
) (
  input  logic        clk_i,
  input  logic [10:0] key_i,
  output logic        hit_o
);
  logic stb_q;
  // The strobe tracks unconditionally, so a toggle seen during reset or load never fires later.
  always_ff @(posedge clk_i) stb_q <= key_i[STB];
  assign hit_o = (key_i[STB] != stb_q) && key_i[PRESSED] && !key_i[EXT] && (key_i[7:0] == HOTKEY);
endmodule

// File: rtl/boot_video_cfg.sv
// boot_video_cfg: holds the core in reset while loading the video settings byte from SRAM, then passes SRAM traffic through.
module boot_video_cfg
  import ondra_pkg::*;
#(
  parameter logic [18:0] CFG_ADDR = CFG_ADDR_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  HOTKEY = PS2_SCROLLLOCK
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [18:0] core_sram_addr,
  input  logic        core_sram_we,
  input  logic [7:0]  sram_data_in,
  input  logic [10:0] ps2_key,
  output logic [18:0] sram_addr,
  output logic        sram_we,
  output logic        core_reset_n,
  output logic [7:0]  cfg_byte,
  output logic        scandoubler_en,
  output logic        cfg_valid
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cfg_q, cfg_d;
  logic       valid_q, valid_d;
  logic       sd_q, sd_d;
  logic       hit;
  logic       run;
  ps2_hotkey_det #(.HOTKEY(HOTKEY)) u_det (
    .clk_i (clk_sys),
    .key_i (ps2_key),
    .hit_o (hit)
  );
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= 4'd0;
      cfg_q   <= 8'h00;
      valid_q <= 1'b0;
      sd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      sd_q    <= sd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    sd_d    = sd_q;
    case (state_q)
      HOLD: begin
        cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        state_d = (cnt_q == SETTLE_LAST) ? SAMPLE : HOLD;
      end
      SAMPLE: begin
        cfg_d   = sram_data_in;
        valid_d = 1'b1;
        sd_d    = ~sram_data_in[0];
        state_d = RELEASE;
      end
      RELEASE: state_d = RUN;
      RUN: begin
        cfg_d[0] = hit ? ~cfg_q[0] : cfg_q[0];
        sd_d     = hit ? cfg_q[0] : sd_q;
      end
    endcase
  end
  assign run            = (state_q == RUN);
  assign core_reset_n   = run;
  assign sram_addr      = run ? core_sram_addr : CFG_ADDR;
  assign sram_we        = run ? core_sram_we : 1'b1;
  assign cfg_byte       = cfg_q;
  assign cfg_valid      = valid_q;
  assign scandoubler_en = sd_q;
endmodule

// File: tb/tb_boot_video_cfg.sv
// tb_boot_video_cfg: randomized self-checking bench for boot_video_cfg against a behavioural model.
module tb_boot_video_cfg;
  localparam logic [18:0] CFG = 19'h08FD5;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] core_sram_addr = '0;
  logic        core_sram_we = 1'b1;
  logic [7:0]  sram_data_in = 8'h00;
  logic [10:0] ps2_key = '0;
  logic [18:0] sram_addr;
  logic        sram_we, core_reset_n, scandoubler_en, cfg_valid;
  logic [7:0]  cfg_byte;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_cfg = 8'h00;
  logic       m_sd = 1'b1;
  logic       m_run = 1'b0;

  always #5 clk_sys = ~clk_sys;

  boot_video_cfg dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .core_sram_addr (core_sram_addr),
    .core_sram_we   (core_sram_we),
    .sram_data_in   (sram_data_in),
    .ps2_key        (ps2_key),
    .sram_addr      (sram_addr),
    .sram_we        (sram_we),
    .core_reset_n   (core_reset_n),
    .cfg_byte       (cfg_byte),
    .scandoubler_en (scandoubler_en),
    .cfg_valid      (cfg_valid)
  );

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  // Flip the strobe with a new key, take one edge, and apply the hotkey rule to the model.
  task automatic key_event(input logic p, input logic e, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, e, c};
    step;
    if (m_run && p && !e && c == 8'h7E) m_cfg[0] = ~m_cfg[0];
    if (m_run) m_sd = ~m_cfg[0];
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    core_sram_we = 1'b0;
    core_sram_addr = 19'h7FFFF;
    m_run = 1'b0;
    step;
    step;
    checks++;
    if (core_reset_n !== 1'b0) begin failures++; $display("FAIL reset_core_reset_n: got %b exp 0", core_reset_n); end
    checks++;
    if (sram_addr !== CFG || sram_we !== 1'b1) begin failures++; $display("FAIL reset_mux: got addr=%h we=%b exp addr=%h we=1", sram_addr, sram_we, CFG); end
    checks++;
    if (cfg_byte !== 8'h00 || cfg_valid !== 1'b0 || scandoubler_en !== 1'b1) begin
      failures++; $display("FAIL reset_regs: got cfg=%h valid=%b sd=%b exp cfg=00 valid=0 sd=1", cfg_byte, cfg_valid, scandoubler_en);
    end
  endtask

  task automatic test_boot(input logic [7:0] data, input bit coincide);
    sram_data_in = data;
    core_sram_addr = 19'($urandom);
    core_sram_we = 1'b0;
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 2 || (i == 5 && coincide)) ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h7E};
      checks++;
      if (sram_addr !== CFG || sram_we !== 1'b1 || core_reset_n !== 1'b0) begin
        failures++; $display("FAIL boot_hold_c%0d: got addr=%h we=%b crst=%b exp addr=%h we=1 crst=0", i, sram_addr, sram_we, core_reset_n, CFG);
      end
      step;
      if (i == 4) begin
        checks++;
        if (cfg_valid !== 1'b0) begin failures++; $display("FAIL boot_valid_early: got %b exp 0", cfg_valid); end
      end
      if (i == 5) begin
        checks++;
        if (cfg_valid !== 1'b1 || cfg_byte !== data) begin
          failures++; $display("FAIL boot_sample: got valid=%b cfg=%h exp valid=1 cfg=%h", cfg_valid, cfg_byte, data);
        end
      end
    end
    m_run = 1'b1;
    m_cfg = data;
    m_sd = ~data[0];
    checks++;
    if (core_reset_n !== 1'b1) begin failures++; $display("FAIL boot_release: got core_reset_n=%b exp 1", core_reset_n); end
    checks++;
    if (cfg_byte !== m_cfg || scandoubler_en !== m_sd) begin
      failures++; $display("FAIL boot_result: got cfg=%h sd=%b exp cfg=%h sd=%b", cfg_byte, scandoubler_en, m_cfg, m_sd);
    end
  endtask

  task automatic test_hotkey_directed;
    logic [3:0] p_tab [6] = '{1, 1, 0, 1, 1, 1};
    logic [3:0] e_tab [6] = '{0, 0, 0, 1, 0, 0};
    logic [7:0] c_tab [6] = '{8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7C, 8'h7E};
    for (int i = 0; i < 6; i++) begin
      key_event(p_tab[i][0], e_tab[i][0], c_tab[i]);
      checks++;
      if (cfg_byte !== m_cfg || scandoubler_en !== m_sd) begin
        failures++; $display("FAIL hotkey_dir_%0d: got cfg=%h sd=%b exp cfg=%h sd=%b", i, cfg_byte, scandoubler_en, m_cfg, m_sd);
      end
    end
    step;
    checks++;
    if (cfg_byte !== m_cfg || scandoubler_en !== m_sd) begin
      failures++; $display("FAIL hotkey_idle: got cfg=%h sd=%b exp cfg=%h sd=%b", cfg_byte, scandoubler_en, m_cfg, m_sd);
    end
  endtask

  task automatic test_hotkey_random;
    logic [7:0] c;
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 2) != 0) ? 8'h7E : 8'($urandom);
      key_event(1'($urandom), 1'($urandom_range(0, 3) == 0), c);
      if ($urandom_range(0, 3) == 0) step;
      checks++;
      if (cfg_byte !== m_cfg || scandoubler_en !== m_sd) begin
        failures++; $display("FAIL hotkey_rnd_%0d: got cfg=%h sd=%b exp cfg=%h sd=%b", i, cfg_byte, scandoubler_en, m_cfg, m_sd);
      end
    end
  endtask

  task automatic test_passthrough;
    for (int i = 0; i < 10; i++) begin
      core_sram_addr = (i == 0) ? 19'h12345 : 19'($urandom);
      core_sram_we = (i == 0) ? 1'b0 : 1'($urandom);
      #1;
      checks++;
      if (sram_addr !== core_sram_addr || sram_we !== core_sram_we) begin
        failures++; $display("FAIL pass_%0d: got addr=%h we=%b exp addr=%h we=%b", i, sram_addr, sram_we, core_sram_addr, core_sram_we);
      end
      step;
    end
  endtask

  task automatic test_reset_mid_run;
    sram_data_in = 8'h01;
    core_sram_we = 1'b0;
    reset_n = 1'b0;
    m_run = 1'b0;
    step;
    checks++;
    if (core_reset_n !== 1'b0 || sram_addr !== CFG || sram_we !== 1'b1) begin
      failures++; $display("FAIL midrst_mux: got crst=%b addr=%h we=%b exp crst=0 addr=%h we=1", core_reset_n, sram_addr, sram_we, CFG);
    end
    checks++;
    if (cfg_valid !== 1'b0 || cfg_byte !== 8'h00 || scandoubler_en !== 1'b1) begin
      failures++; $display("FAIL midrst_regs: got valid=%b cfg=%h sd=%b exp valid=0 cfg=00 sd=1", cfg_valid, cfg_byte, scandoubler_en);
    end
    test_boot(8'h01, 1'b0);
  endtask

  initial begin
    test_reset;
    test_boot(8'h00, 1'b0);
    test_hotkey_directed;
    test_passthrough;
    test_reset;
    test_boot(8'h01, 1'b0);
    test_passthrough;
    test_hotkey_random;
    test_reset;
    test_boot(8'h00, 1'b1);
    test_hotkey_random;
    test_reset_mid_run;
    test_hotkey_directed;
    test_reset;
    test_boot(8'($urandom), 1'b1);
    test_hotkey_random;
    test_passthrough;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
